// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl_pkg
//  Purpose  : Shared types, constants and helper functions for the pipeline
//             hazard controller (FSM state enum, forward-select enum, counter
//             width, register-match helpers).
//  Revision : 1.0  initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    localparam int COUNTER_WIDTH = 16;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

    // A nonzero destination that matches either ID source register.
    // Register $0 is hardwired, so it can never create a dependency.
    function automatic logic reg_hit(input logic [4:0] dst,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt);
        return (dst != 5'd0) && ((dst == rs) || (dst == rt));
    endfunction

    // Operand source select; the younger EX/MEM result wins over MEM/WB.
    function automatic fwd_e fwd_sel(input logic       mem_we,
                                     input logic [4:0] mem_dst,
                                     input logic       wb_we,
                                     input logic [4:0] wb_dst,
                                     input logic [4:0] src);
        if (mem_we && (mem_dst != 5'd0) && (mem_dst == src)) begin
            return FWD_MEM;
        end
        if (wb_we && (wb_dst != 5'd0) && (wb_dst == src)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Saturating up-counter used for the hazard performance counters.
//  Ports    : clk      - clock
//             reset    - asynchronous active-low reset, clears the count
//             inc_i    - increment request for this cycle
//             count_o  - current count, sticks at all-ones
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Hazard controller for a 5-stage pipeline: memory-wait freeze,
//             branch flush, load-use (or full RAW, without forwarding) stall,
//             ALU operand forwarding and stall/flush performance counters.
//  Ports    : clk, reset (async active-low)
//             idRs/idRt, exRs/exRt            - source registers in ID / EX
//             exRegWrite/exMemRead/exRegWriteAddress   - ID/EX controls
//             memRegWrite/memReq/memRegWriteAddress    - EX/MEM controls
//             wbRegWrite/wbRegWriteAddress             - MEM/WB controls
//             memReady, branchTaken                    - status inputs
//             pcWrite, ifIdWrite, ifIdFlush, idExFlush, idExHold,
//             exMemHold, memWbBubble                   - pipeline controls
//             forwardA/forwardB                        - ALU operand select
//             stallCount/flushCount                    - perf counters
//  Config   : FORWARDING_EN - enables EX/MEM and MEM/WB forwarding; when
//             undefined, forwards are tied to register-file and every
//             in-flight RAW dependency stalls instead.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [4:0]               idRs,
    input  logic [4:0]               idRt,
    input  logic [4:0]               exRs,
    input  logic [4:0]               exRt,
    input  logic                     exRegWrite,
    input  logic                     exMemRead,
    input  logic [4:0]               exRegWriteAddress,
    input  logic                     memRegWrite,
    input  logic                     memReq,
    input  logic [4:0]               memRegWriteAddress,
    input  logic                     wbRegWrite,
    input  logic [4:0]               wbRegWriteAddress,
    input  logic                     memReady,
    input  logic                     branchTaken,
    output logic                     pcWrite,
    output logic                     ifIdWrite,
    output logic                     ifIdFlush,
    output logic                     idExFlush,
    output logic                     idExHold,
    output logic                     exMemHold,
    output logic                     memWbBubble,
    output logic [1:0]               forwardA,
    output logic [1:0]               forwardB,
    output logic [COUNTER_WIDTH-1:0] stallCount,
    output logic [COUNTER_WIDTH-1:0] flushCount
);

    state_e state_q;
    state_e state_d;

    logic   w_freeze;
    logic   w_flush;
    logic   w_stall_hit;
    logic   w_load_use;
    fwd_e   w_fwd_a;
    fwd_e   w_fwd_b;

    // Freeze is purely combinational so the cycle memReady rises already
    // advances the pipeline, whichever FSM state we are in.
    assign w_freeze = memReq & ~memReady;
    assign w_flush  = branchTaken & ~w_freeze;

`ifdef FORWARDING_EN
    // Only a load in EX cannot be forwarded in time.
    assign w_stall_hit = exMemRead & reg_hit(exRegWriteAddress, idRs, idRt);

    assign w_fwd_a = fwd_sel(memRegWrite, memRegWriteAddress,
                             wbRegWrite, wbRegWriteAddress, exRs);
    assign w_fwd_b = fwd_sel(memRegWrite, memRegWriteAddress,
                             wbRegWrite, wbRegWriteAddress, exRt);

    logic w_unused;
    assign w_unused = exRegWrite;
`else
    // No bypass paths: any younger producer still in EX or MEM must drain.
    // WB is excluded because the register file writes in the first half.
    assign w_stall_hit = ((exMemRead | exRegWrite)
                          & reg_hit(exRegWriteAddress, idRs, idRt))
                       | (memRegWrite & reg_hit(memRegWriteAddress, idRs, idRt));

    assign w_fwd_a = FWD_REG;
    assign w_fwd_b = FWD_REG;

    logic w_unused;
    assign w_unused = ^{exRs, exRt, wbRegWrite, wbRegWriteAddress};
`endif

    assign w_load_use = w_stall_hit & ~w_freeze & ~w_flush;

    // Priority: reset, freeze, flush, load-use, idle.
    always_comb begin
        pcWrite     = 1'b1;
        ifIdWrite   = 1'b1;
        ifIdFlush   = 1'b0;
        idExFlush   = 1'b0;
        idExHold    = 1'b0;
        exMemHold   = 1'b0;
        memWbBubble = 1'b0;
        forwardA    = w_fwd_a;
        forwardB    = w_fwd_b;
        if (!reset) begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            memWbBubble = 1'b1;
            forwardA    = FWD_REG;
            forwardB    = FWD_REG;
        end else if (w_freeze) begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            idExHold    = 1'b1;
            exMemHold   = 1'b1;
            memWbBubble = 1'b1;
        end else if (w_flush) begin
            ifIdFlush   = 1'b1;
            idExFlush   = 1'b1;
        end else if (w_load_use) begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            idExFlush   = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:      if (w_freeze) state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: if (memReady) state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    sat_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (w_freeze | w_load_use),
        .count_o (stallCount)
    );

    sat_counter #(.WIDTH(COUNTER_WIDTH)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (w_flush),
        .count_o (flushCount)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Self-checking bench for pipeline_hazard_ctrl: directed hazard
//             scenarios, random stimulus against a behavioural model, async
//             reset in MEM_WAIT and counter saturation.
//  Config   : FORWARDING_EN - must match the RTL build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  idRs, idRt, exRs, exRt;
    logic        exRegWrite, exMemRead;
    logic [4:0]  exRegWriteAddress;
    logic        memRegWrite, memReq;
    logic [4:0]  memRegWriteAddress;
    logic        wbRegWrite;
    logic [4:0]  wbRegWriteAddress;
    logic        memReady, branchTaken;
    logic        pcWrite, ifIdWrite, ifIdFlush, idExFlush, idExHold, exMemHold, memWbBubble;
    logic [1:0]  forwardA, forwardB;
    logic [15:0] stallCount, flushCount;

    pipeline_hazard_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .idRs               (idRs),
        .idRt               (idRt),
        .exRs               (exRs),
        .exRt               (exRt),
        .exRegWrite         (exRegWrite),
        .exMemRead          (exMemRead),
        .exRegWriteAddress  (exRegWriteAddress),
        .memRegWrite        (memRegWrite),
        .memReq             (memReq),
        .memRegWriteAddress (memRegWriteAddress),
        .wbRegWrite         (wbRegWrite),
        .wbRegWriteAddress  (wbRegWriteAddress),
        .memReady           (memReady),
        .branchTaken        (branchTaken),
        .pcWrite            (pcWrite),
        .ifIdWrite          (ifIdWrite),
        .ifIdFlush          (ifIdFlush),
        .idExFlush          (idExFlush),
        .idExHold           (idExHold),
        .exMemHold          (exMemHold),
        .memWbBubble        (memWbBubble),
        .forwardA           (forwardA),
        .forwardB           (forwardB),
        .stallCount         (stallCount),
        .flushCount         (flushCount)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: plain integers and a wait flag.
    int m_stall = 0;
    int m_flush = 0;
    bit m_wait  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit dep(input logic [4:0] d);
        return (d != 5'd0) && (d == idRs || d == idRt);
    endfunction

    function automatic int fwd_exp(input logic [4:0] src);
        if (!FWD) return 0;
        if (memRegWrite && memRegWriteAddress != 0 && memRegWriteAddress == src) return 2;
        if (wbRegWrite && wbRegWriteAddress != 0 && wbRegWriteAddress == src) return 1;
        return 0;
    endfunction

    task automatic idle_inputs();
        idRs = 0; idRt = 0; exRs = 0; exRt = 0;
        exRegWrite = 0; exMemRead = 0; exRegWriteAddress = 0;
        memRegWrite = 0; memReq = 0; memRegWriteAddress = 0;
        wbRegWrite = 0; wbRegWriteAddress = 0;
        memReady = 0; branchTaken = 0;
    endtask

    // One clock: check outputs/counters/state at the falling edge against
    // the model, then advance the model to what the rising edge commits.
    task automatic step();
        bit frz, fl, lu;
        bit [6:0] ctl;   // {pc, ifw, iff, idf, idh, exh, bub}
        int fa, fb;
        @(negedge clk);
        frz = memReq && !memReady;
        fl  = !frz && branchTaken;
        lu  = !frz && !fl &&
              ((exMemRead && dep(exRegWriteAddress)) ||
               (!FWD && ((exRegWrite && dep(exRegWriteAddress)) ||
                         (memRegWrite && dep(memRegWriteAddress)))));
        fa = fwd_exp(exRs);
        fb = fwd_exp(exRt);
        if (!reset)   begin ctl = 7'b0000001; fa = 0; fb = 0; end
        else if (frz) ctl = 7'b0000111;
        else if (fl)  ctl = 7'b1111000;
        else if (lu)  ctl = 7'b0001000;
        else          ctl = 7'b1100000;
        check("pcWrite",     pcWrite,     ctl[6]);
        if (!(reset && fl)) check("ifIdWrite", ifIdWrite, ctl[5]);
        check("ifIdFlush",   ifIdFlush,   ctl[4]);
        check("idExFlush",   idExFlush,   ctl[3]);
        check("idExHold",    idExHold,    ctl[2]);
        check("exMemHold",   exMemHold,   ctl[1]);
        check("memWbBubble", memWbBubble, ctl[0]);
        check("forwardA",    forwardA,    fa);
        check("forwardB",    forwardB,    fb);
        check("stallCount",  stallCount,  m_stall);
        check("flushCount",  flushCount,  m_flush);
        check("state",       dut.state_q, m_wait ? ST_MEM_WAIT : ST_RUN);
        if (!reset) begin
            m_stall = 0; m_flush = 0; m_wait = 1'b0;
        end else begin
            if ((frz || lu) && m_stall < 65535) m_stall++;
            if (fl && m_flush < 65535) m_flush++;
            if (!m_wait && frz) m_wait = 1'b1;
            else if (m_wait && memReady) m_wait = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();

        // Load-use on idRs.
        exMemRead = 1; exRegWriteAddress = 8; idRs = 8;
        step();
        idle_inputs();
        step();
        check("loaduse_stall", stallCount, 1);

        // Three-cycle memory wait then completion.
        memReq = 1; memReady = 0;
        step();
        step();
        check("mw_state", dut.state_q, ST_MEM_WAIT);
        step();
        memReady = 1;
        step();
        idle_inputs();
        step();
        check("mw_stall", stallCount, 4);
        check("mw_run", dut.state_q, ST_RUN);

        // Branch coincident with load-use: flush wins.
        branchTaken = 1; exMemRead = 1; exRegWriteAddress = 8; idRs = 8;
        step();
        idle_inputs();
        step();
        check("br_flush", flushCount, 1);
        check("br_stall", stallCount, 4);

        // Forward priority and $0.
        memRegWrite = 1; memRegWriteAddress = 5; wbRegWrite = 1; wbRegWriteAddress = 5;
        exRs = 5; exRt = 0;
        step();
        exRs = 0; exRt = 5; memRegWrite = 0;
        step();
        idle_inputs();

        // $0 load never stalls.
        exMemRead = 1; exRegWrite = 1; exRegWriteAddress = 0;
        step();
        idle_inputs();

        // Async reset in MEM_WAIT.
        memReq = 1; memReady = 0;
        step();
        step();
        #3;
        reset = 1'b0;
        #1;
        check("arst_state", dut.state_q, ST_RUN);
        check("arst_stall", stallCount, 0);
        check("arst_flush", flushCount, 0);
        check("arst_pcWrite", pcWrite, 0);
        check("arst_bubble", memWbBubble, 1);
        m_stall = 0; m_flush = 0; m_wait = 1'b0;
        step();
        reset = 1'b1;
        idle_inputs();
        step();

        // Random stimulus.
        for (int i = 0; i < 2000; i++) begin
            idRs = 5'($urandom_range(0, 3));
            idRt = 5'($urandom_range(0, 3));
            exRs = 5'($urandom_range(0, 3));
            exRt = 5'($urandom_range(0, 3));
            exRegWrite = 1'($urandom_range(0, 1));
            exMemRead = 1'($urandom_range(0, 1));
            exRegWriteAddress = 5'($urandom_range(0, 3));
            memRegWrite = 1'($urandom_range(0, 1));
            memRegWriteAddress = 5'($urandom_range(0, 3));
            wbRegWrite = 1'($urandom_range(0, 1));
            wbRegWriteAddress = 5'($urandom_range(0, 3));
            memReq = ($urandom_range(0, 3) == 0);
            memReady = 1'($urandom_range(0, 1));
            branchTaken = ($urandom_range(0, 4) == 0);
            step();
        end
        idle_inputs();
        step();

        // Long freeze: counter must stick at all-ones.
        memReq = 1; memReady = 0;
        step();
        for (int i = 0; i < 70000; i++) @(posedge clk);
        #1;
        m_stall = (m_stall + 70000 > 65535) ? 65535 : m_stall + 70000;
        m_wait = 1'b1;
        check("sat_value", stallCount, 16'hFFFF);
        step();
        step();
        check("sat_nowrap", stallCount, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the inputs idRs and idRt, 5 bits each: source registers of the instruction in ID.
REQ-004 The block SHALL have the inputs exRs and exRt, 5 bits each: source registers of the instruction in EX.
REQ-005 The block SHALL have the inputs exRegWrite and exMemRead, 1 bit each, and exRegWriteAddress, 5 bits: ID/EX control outputs.
REQ-006 The block SHALL have the inputs memRegWrite and memReq, 1 bit each, and memRegWriteAddress, 5 bits: EX/MEM outputs; memReq = memRead | memWrite.
REQ-007 The block SHALL have the inputs wbRegWrite, 1 bit, and wbRegWriteAddress, 5 bits: MEM/WB outputs.
REQ-008 The block SHALL have the input memReady, 1 bit: data memory completes the access this cycle.
REQ-009 The block SHALL have the input branchTaken, 1 bit: a branch resolved taken in EX.
REQ-010 The block SHALL have the outputs pcWrite, ifIdWrite, ifIdFlush, idExFlush, idExHold, exMemHold and memWbBubble, 1 bit each: pipeline register controls.
REQ-011 The block SHALL have the outputs forwardA and forwardB, 2 bits each: ALU operand source select.
REQ-012 The block SHALL have the outputs stallCount and flushCount, 16 bits each: performance counters.

Function
REQ-013 The freeze condition SHALL be memReq & !memReady, evaluated combinationally in both FSM states.
REQ-014 During freeze, pcWrite, ifIdWrite and all flushes SHALL be 0, idExHold and exMemHold SHALL be 1, and memWbBubble SHALL be 1; freeze has the highest priority.
REQ-015 The flush condition SHALL be branchTaken while not frozen; it SHALL drive ifIdFlush=1 and idExFlush=1, with pcWrite=1.
REQ-016 The load-use condition SHALL be: exMemRead, exRegWriteAddress!=0, and exRegWriteAddress equals idRs or idRt, while not frozen and not flushing.
REQ-017 On a load-use condition, the block SHALL drive pcWrite=0, ifIdWrite=0 and idExFlush=1 for exactly that cycle.
REQ-018 In the idle case, the block SHALL drive pcWrite=1, ifIdWrite=1, and all flush, hold and bubble outputs 0.
REQ-019 The FSM states SHALL be RUN and MEM_WAIT: RUN->MEM_WAIT on freeze; MEM_WAIT->RUN when memReady=1; otherwise the state stays.
REQ-020 The cycle in which memReady rises SHALL advance the pipeline, with no freeze.
REQ-021 stallCount SHALL increment by 1 on every freeze or load-use cycle and saturate at 16'hFFFF.
REQ-022 flushCount SHALL increment on every flush cycle and saturate at 16'hFFFF.
REQ-023 Register $0 SHALL never cause a stall or a forward.
REQ-024 The register file writes in the first half-cycle, so the WB stage SHALL never create an ID hazard.

Reset
REQ-025 While reset=0, the state SHALL be RUN and both counters SHALL be 0.
REQ-026 While reset=0, the outputs SHALL be: pcWrite=0, ifIdWrite=0, all flush and hold outputs 0, memWbBubble=1, forwardA=forwardB=00.
REQ-027 Reset asserted mid-MEM_WAIT SHALL return the FSM to RUN immediately, without waiting for memReady.

Configuration
REQ-028 With FORWARDING_EN defined, forwardA SHALL be 10 if memRegWrite & memRegWriteAddress!=0 & memRegWriteAddress==exRs.
REQ-029 With FORWARDING_EN defined, otherwise forwardA SHALL be 01 if the same condition holds with wb* in place of mem*; otherwise 00; forwardB SHALL use exRt likewise; EX/MEM has priority.
REQ-030 Without FORWARDING_EN, forwardA and forwardB SHALL be tied to 00.
REQ-031 Without FORWARDING_EN, the stall condition SHALL extend REQ-016 to any exRegWrite, or memRegWrite, destination that is nonzero and matches idRs or idRt.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the forward-select enum (FWD_REG=00, FWD_WB=01, FWD_MEM=10) and COUNTER_WIDTH=16.
REQ-033 A single sub-module, sat_counter, SHALL be instantiated twice for the counters.

Verification
REQ-034 exMemRead=1, exRegWriteAddress=8, idRs=8 -> one cycle of pcWrite=0, ifIdWrite=0, idExFlush=1; stallCount 0->1.
REQ-035 memReq=1 with memReady=0 for 3 cycles, then 1 -> 3 frozen cycles, state MEM_WAIT, then RUN; stallCount=3.
REQ-036 branchTaken=1 simultaneously with a load-use hazard -> ifIdFlush=idExFlush=1, pcWrite=1; flushCount=1, stallCount unchanged.
REQ-037 With FORWARDING_EN: memRegWriteAddress=wbRegWriteAddress=5, exRs=5, both write enables 1 -> forwardA=10; exRt=0 -> forwardB=00.
REQ-038 reset driven low during MEM_WAIT with memReady=0 -> state RUN and counters 0 asynchronously; outputs per REQ-026.
REQ-039 Hold freeze for 70000 cycles -> stallCount saturates at 16'hFFFF and does not wrap.
